// File: rtl/async_event_capture_pkg.sv
// async_event_capture_pkg: FSM encodings and default parameters shared by the capture path
package async_event_capture_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_e;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/async_event_capture_sync_filter.sv
// async_event_capture_sync_filter: synchronizer chain, persistence filter and edge pulses
module async_event_capture_sync_filter
  import async_event_capture_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic CLK,
  input  logic RST,
  input  logic DIN,
  output logic DOUT,
  output logic RISE,
  output logic FALL
);
  localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILT_LEN - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic dout_q, dout_d, rise_q, fall_q, sync, flip;
  // the level is accepted only after differing from DOUT for FILT_LEN consecutive edges
  always_comb begin
    sync = sync_q[SYNC_STAGES-1];
    flip = sync != dout_q && fcnt_q == FMAX;
    fcnt_d = (sync == dout_q || flip) ? '0 : fcnt_q + FW'(1);
    dout_d = flip ? sync : dout_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      fcnt_q <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], DIN};
      fcnt_q <= fcnt_d;
      dout_q <= dout_d;
      rise_q <= flip && sync;
      fall_q <= flip && !sync;
    end
  end
  assign DOUT = dout_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
endmodule

// File: rtl/async_event_capture.sv
// async_event_capture: brings an async level into CLK, counts rising events, VALID/ACK handoff
module async_event_capture
  import async_event_capture_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN = DEF_FILT_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN,
  input  logic             ACK,
  output logic             DOUT,
  output logic             RISE,
  output logic             FALL,
  output logic             VALID,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic             OVF
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, acc;
  async_event_capture_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN(FILT_LEN)
  ) u_sync_filter (
    .CLK(CLK),
    .RST(RST),
    .DIN(DIN),
    .DOUT(DOUT),
    .RISE(RISE),
    .FALL(FALL)
  );
  // an accepted ACK hands the current count to the consumer; a coincident rise starts the next batch
  always_comb begin
    acc = ACK && state_q == ST_PEND;
    state_d = RISE ? ST_PEND : acc ? ST_IDLE : state_q;
    cnt_d = acc ? CNT_W'(RISE) : (RISE && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = acc ? 1'b0 : ovf_q | (RISE && cnt_q == CNT_MAX);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign VALID = state_q == ST_PEND;
  assign EVT_CNT = cnt_q;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_async_event_capture.sv
// tb_async_event_capture: directed and random stimulus against a history-based reference model
module tb_async_event_capture;
  localparam int S0 = 2, F0 = 4, W0 = 8;
  localparam int S1 = 3, F1 = 1, W1 = 2;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0, ack = 1'b0;
  logic [1:0] dout_w, rise_w, fall_w, valid_w, ovf_w;
  logic [W0-1:0] cnt0;
  logic [W1-1:0] cnt1;
  int n_cmp = 0, n_bad = 0, rises0 = 0;
  bit din_log[$];
  bit m_dout[2], m_rise[2], m_fall[2], m_valid[2], m_ovf[2];
  int m_cnt[2];

  async_event_capture #(.SYNC_STAGES(S0), .FILT_LEN(F0), .CNT_W(W0)) dut0 (
    .CLK(clk), .RST(rst), .DIN(din), .ACK(ack), .DOUT(dout_w[0]), .RISE(rise_w[0]),
    .FALL(fall_w[0]), .VALID(valid_w[0]), .EVT_CNT(cnt0), .OVF(ovf_w[0])
  );
  async_event_capture #(.SYNC_STAGES(S1), .FILT_LEN(F1), .CNT_W(W1)) dut1 (
    .CLK(clk), .RST(rst), .DIN(din), .ACK(ack), .DOUT(dout_w[1]), .RISE(rise_w[1]),
    .FALL(fall_w[1]), .VALID(valid_w[1]), .EVT_CNT(cnt1), .OVF(ovf_w[1])
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SYNC seen before edge m (m counted from 1 after reset) is DIN as sampled S edges earlier
  function automatic bit sync_pre(int i, int m);
    int s = i ? S1 : S0;
    return (m - s >= 1) ? din_log[m-s-1] : 1'b0;
  endfunction

  task automatic model_step();
    if (rst) begin
      din_log.delete();
      for (int i = 0; i < 2; i++) begin
        m_dout[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      din_log.push_back(din);
      for (int i = 0; i < 2; i++) begin
        int f = i ? F1 : F0;
        int mx = i ? (1 << W1) - 1 : (1 << W0) - 1;
        int n = din_log.size();
        bit acc = ack && m_valid[i];
        bit r = m_rise[i];
        bit flip = n >= f;
        m_ovf[i] = acc ? 1'b0 : (m_ovf[i] || (r && m_cnt[i] == mx));
        m_cnt[i] = acc ? int'(r) : r ? (m_cnt[i] < mx ? m_cnt[i] + 1 : mx) : m_cnt[i];
        m_valid[i] = r ? 1'b1 : acc ? 1'b0 : m_valid[i];
        for (int j = 0; j < f; j++) if (sync_pre(i, n - j) == m_dout[i]) flip = 0;
        m_rise[i] = flip && !m_dout[i];
        m_fall[i] = flip && m_dout[i];
        if (flip) m_dout[i] = !m_dout[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (rise_w[0]) rises0++;
    chk("dout0", dout_w[0], m_dout[0]);
    chk("rise0", rise_w[0], m_rise[0]);
    chk("fall0", fall_w[0], m_fall[0]);
    chk("valid0", valid_w[0], m_valid[0]);
    chk("ovf0", ovf_w[0], m_ovf[0]);
    chk("cnt0", cnt0, m_cnt[0]);
    chk("dout1", dout_w[1], m_dout[1]);
    chk("rise1", rise_w[1], m_rise[1]);
    chk("fall1", fall_w[1], m_fall[1]);
    chk("valid1", valid_w[1], m_valid[1]);
    chk("ovf1", ovf_w[1], m_ovf[1]);
    chk("cnt1", cnt1, m_cnt[1]);
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    din = 1; ticks(8);
    din = 0; ticks(8);
  endtask

  task automatic ack1();
    ack = 1; tick(); ack = 0;
  endtask

  initial begin
    int r0, k, hold;
    rst = 1; ticks(2);
    chk("rst_dout", dout_w[0], 0);
    chk("rst_cnt", cnt0, 0);
    rst = 0; din = 1;
    ticks(5);
    chk("lat_pre", dout_w[0], 0);
    tick();
    chk("lat_dout", dout_w[0], 1);
    chk("lat_rise", rise_w[0], 1);
    tick();
    chk("lat_valid", valid_w[0], 1);
    chk("lat_cnt", cnt0, 1);
    chk("lat_fall", fall_w[0], 0);
    din = 0; ticks(10); ack1();
    chk("clr_valid", valid_w[0], 0);
    r0 = rises0; din = 1; ticks(3); din = 0; ticks(12);
    chk("glitch3", rises0 - r0, 0);
    chk("glitch3_valid", valid_w[0], 0);
    r0 = rises0; din = 1; ticks(4); din = 0; ticks(12);
    chk("glitch4", rises0 - r0, 1);
    ack1();
    repeat (3) pulse();
    chk("three_cnt", cnt0, 3);
    chk("three_valid", valid_w[0], 1);
    ack1();
    chk("three_ack_cnt", cnt0, 0);
    chk("three_ack_valid", valid_w[0], 0);
    repeat (2) pulse();
    din = 1; k = 0;
    while (!rise_w[0] && k < 20) begin tick(); k++; end
    chk("ackrise_wait", rise_w[0], 1);
    ack1();
    chk("ackrise_cnt", cnt0, 1);
    chk("ackrise_valid", valid_w[0], 1);
    din = 0; ticks(10); ack1();
    ack = 1; ticks(2); ack = 0;
    chk("idle_ack_valid", valid_w[0], 0);
    chk("idle_ack_cnt", cnt0, 0);
    repeat (5) pulse();
    chk("sat_cnt", cnt1, 3);
    chk("sat_ovf", ovf_w[1], 1);
    ack1();
    chk("sat_ack_ovf", ovf_w[1], 0);
    chk("sat_ack_cnt", cnt1, 0);
    pulse();
    din = 1; ticks(4);
    rst = 1; tick(); rst = 0;
    chk("midrst_dout", dout_w[0], 0);
    chk("midrst_valid", valid_w[0], 0);
    ticks(5);
    chk("midrst_pre", dout_w[0], 0);
    tick();
    chk("midrst_dout_again", dout_w[0], 1);
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        din = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      ack = $urandom_range(0, 5) == 0;
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 0; ack = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/async_event_capture.md
Name: async_event_capture

Overview:
Downstream consumer of the asynchronous flip-flop stage: takes its data output Q, which changes on a derived clock edge, into the main CLK domain. Synchronizes, glitch-filters and edge-detects the level, then counts rising events and offers them to a synchronous consumer via a VALID/ACK handshake. All logic is single-clock synchronous; no derived clocks.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the synchronizer chain (legal range 2..4)
FILT_LEN, 4, consecutive CLK cycles a new synchronized level must persist before DOUT accepts it (1 = filter bypassed)
CNT_W, 8, width of the event counter

Ports:
CLK  input  1  system clock; all state updates on its rising edge
RST  input  1  synchronous, active-high reset
DIN  input  1  asynchronous level from the upstream stage's Q output
ACK  input  1  consumer acknowledge; meaningful only while VALID=1
DOUT  output  1  synchronized, filtered level
RISE  output  1  one-cycle pulse on a DOUT 0->1 change
FALL  output  1  one-cycle pulse on a DOUT 1->0 change
VALID  output  1  at least one unacknowledged rising event pending
EVT_CNT  output  CNT_W  rising events since the last accepted ACK, saturating
OVF  output  1  sticky: a rise occurred while EVT_CNT was saturated

Behaviour:
- Reset: RST sampled high on a CLK edge clears the synchronizer chain, filter counter, DOUT, RISE, FALL, VALID, EVT_CNT and OVF to 0; FSM goes to IDLE. This takes priority over every other event, including mid-filter and PEND states.
- Synchronizer: DIN shifts through SYNC_STAGES flops. SYNC is the last stage output. No logic sits between stages.
- Filter (counter width clog2(FILT_LEN), minimum 1 bit), per edge:
  - If SYNC==DOUT: counter <= 0.
  - Else if counter==FILT_LEN-1: DOUT <= SYNC and counter <= 0.
  - Else: counter++.
- Latency: DIN settled before edge 1 gives a DOUT change at edge SYNC_STAGES+FILT_LEN (defaults: edge 6; FILT_LEN=1: edge 3).
- Glitch rule: a SYNC excursion shorter than FILT_LEN cycles never changes DOUT.
- RISE/FALL: registered, asserted in the same cycle DOUT takes its new value, high for exactly one cycle; never both high at once.
- FSM states:
  - IDLE (VALID=0).
  - PEND (VALID=1).
  - IDLE -> PEND on RISE.
  - PEND -> IDLE on ACK with no RISE in the same cycle.
  - PEND with ACK and RISE together stays in PEND.
  - ACK is ignored in IDLE.
- EVT_CNT, per edge:
  - RISE and no accepted ACK: increment, saturating at 2^CNT_W-1.
  - Accepted ACK (ACK while VALID=1): EVT_CNT <= 1 if RISE is in the same cycle, else 0.
  - The value at the ACK edge is the value the consumer reads.
- OVF: set on RISE while EVT_CNT==2^CNT_W-1 with no accepted ACK; cleared only by an accepted ACK or RST.
- FALL has no effect on the FSM or the counter.

Decomposition:
- Shared constants header: FSM state encodings ST_IDLE=1'b0 and ST_PEND=1'b1, plus the default parameter values, so neighbouring stages reuse them.
- One sub-module, sync_filter: synchronizer chain, filter counter, DOUT, RISE, FALL; parameters SYNC_STAGES and FILT_LEN.
- The top level holds the FSM, EVT_CNT and OVF.

Test Plan:
- Reset then DIN 0->1 held: DOUT=1 and RISE pulse at edge 6 after DIN changes; VALID=1 and EVT_CNT=1 at edge 7; FALL stays 0.
- Glitch: DIN high for 3 cycles then low -> DOUT, RISE, VALID stay 0 throughout. Repeat with 4-cycle high -> exactly one RISE.
- Three clean DIN pulses (8 high / 8 low each), no ACK -> EVT_CNT=3, VALID=1. ACK for one cycle -> EVT_CNT=0 and VALID=0 next cycle.
- ACK asserted in the same cycle as a RISE while in PEND with EVT_CNT=2 -> EVT_CNT=1, VALID stays 1. ACK while IDLE -> no change.
- CNT_W=2: five rises without ACK -> EVT_CNT=3; OVF=1 after the 4th rise and stays high; ACK -> OVF=0, EVT_CNT=0.
- RST asserted for one cycle mid-filter (counter=2) and in PEND -> all outputs 0 next cycle; DIN still high -> DOUT=1 after a fresh SYNC_STAGES+FILT_LEN edges.
